// File: rtl/speed_loop_control.sv
// rtl/speed_loop_control.sv - speed-loop PI controller producing the q-axis current set value
// Five-state sequenced datapath: capture, error, products, integrator update, saturated output.
module speed_loop_control #(
    parameter int                           DATA_WIDTH = 16,
    parameter logic [15:0]                  KP         = 16'd1024,
    parameter logic [15:0]                  KI         = 16'd256,
    parameter int                           FRAC       = 10,
    parameter logic signed [DATA_WIDTH-1:0] OUT_MAX    = 16'sd8000
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  logic                         speed_loop_control_enable_in,
    input  logic                         integral_clear_in,
    input  logic signed [DATA_WIDTH-1:0] pmsm_speed_set_value_in,
    input  logic signed [DATA_WIDTH-1:0] pmsm_detect_speed_value_in,
    output logic signed [DATA_WIDTH-1:0] pmsm_current_q_set_value_out,
    output logic                         speed_loop_control_done_out,
    output logic                         speed_loop_busy_out
);
    localparam int EW = DATA_WIDTH + 1;
    localparam int PW = EW + 17;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] ACC_LIM = SW'(OUT_MAX) <<< FRAC;
    localparam logic signed [SW-1:0] ACC_NEG = -ACC_LIM;
    localparam logic signed [SW-1:0] OUT_HI  = SW'(OUT_MAX);
    localparam logic signed [SW-1:0] OUT_LO  = -OUT_HI;

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_ACC, S_OUT} state_t;

    state_t state, state_next;
    logic   cap, do_err, do_mul, do_acc, do_out;

    logic signed [DATA_WIDTH-1:0] set_q, det_q;
    logic signed [EW-1:0]         err_q;
    logic signed [PW-1:0]         p_q, i_q, acc, acc_next;
    logic signed [PW-1:0]         kp_w, ki_w, err_w;
    logic signed [SW-1:0]         acc_sum, pi_sum, pi_shift;
    logic signed [DATA_WIDTH-1:0] sat_val;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (speed_loop_control_enable_in) state_next = S_ERR;
            S_ERR:   state_next = S_MUL;
            S_MUL:   state_next = S_ACC;
            S_ACC:   state_next = S_OUT;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        speed_loop_busy_out = 1'b1;
        cap    = 1'b0;
        do_err = 1'b0;
        do_mul = 1'b0;
        do_acc = 1'b0;
        do_out = 1'b0;
        case (state)
            S_IDLE: begin
                speed_loop_busy_out = 1'b0;
                cap = speed_loop_control_enable_in;
            end
            S_ERR:   do_err = 1'b1;
            S_MUL:   do_mul = 1'b1;
            S_ACC:   do_acc = 1'b1;
            S_OUT:   do_out = 1'b1;
            default: speed_loop_busy_out = 1'b0;
        endcase
    end

    // Gains are unsigned, so they enter the signed multiply with a zero MSB.
    assign kp_w  = PW'($signed({1'b0, KP}));
    assign ki_w  = PW'($signed({1'b0, KI}));
    assign err_w = PW'(err_q);

    assign acc_sum = SW'(acc) + SW'(i_q);

    always_comb begin
        if (acc_sum > ACC_LIM)      acc_next = ACC_LIM[PW-1:0];
        else if (acc_sum < ACC_NEG) acc_next = ACC_NEG[PW-1:0];
        else                        acc_next = acc_sum[PW-1:0];
    end

    assign pi_sum   = SW'(p_q) + SW'(acc);
    assign pi_shift = pi_sum >>> FRAC;

    always_comb begin
        if (pi_shift > OUT_HI)      sat_val = OUT_MAX;
        else if (pi_shift < OUT_LO) sat_val = -OUT_MAX;
        else                        sat_val = pi_shift[DATA_WIDTH-1:0];
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            set_q                        <= '0;
            det_q                        <= '0;
            err_q                        <= '0;
            p_q                          <= '0;
            i_q                          <= '0;
            acc                          <= '0;
            pmsm_current_q_set_value_out <= '0;
            speed_loop_control_done_out  <= 1'b0;
        end else begin
            if (cap) begin
                set_q <= pmsm_speed_set_value_in;
                det_q <= pmsm_detect_speed_value_in;
            end
            if (do_err)
                err_q <= $signed({set_q[DATA_WIDTH-1], set_q}) - $signed({det_q[DATA_WIDTH-1], det_q});
            if (do_mul) begin
                p_q <= kp_w * err_w;
                i_q <= ki_w * err_w;
            end
            // Clear has priority so the output computed next uses a zero integrator.
            if (integral_clear_in) acc <= '0;
            else if (do_acc)       acc <= acc_next;
            if (do_out) pmsm_current_q_set_value_out <= sat_val;
            speed_loop_control_done_out <= do_out;
        end
    end
endmodule

// File: tb/tb_speed_loop_control.sv
// tb/tb_speed_loop_control.sv - directed self-checking bench for speed_loop_control
module tb_speed_loop_control;
    logic                sys_clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic                clear;
    logic signed [15:0]  set_v;
    logic signed [15:0]  det_v;
    logic signed [15:0]  q_out;
    logic                done;
    logic                busy;
    int                  checks   = 0;
    int                  failures = 0;

    always #5 sys_clk = ~sys_clk;

    speed_loop_control dut (
        .sys_clk                      (sys_clk),
        .reset_n                      (reset_n),
        .speed_loop_control_enable_in (enable),
        .integral_clear_in            (clear),
        .pmsm_speed_set_value_in      (set_v),
        .pmsm_detect_speed_value_in   (det_v),
        .pmsm_current_q_set_value_out (q_out),
        .speed_loop_control_done_out  (done),
        .speed_loop_busy_out          (busy)
    );

    // Strobe one computation; inputs are scrambled after the sampling edge.
    task automatic run_op(input logic signed [15:0] s, input logic signed [15:0] d, output int lat);
        set_v = s;
        det_v = d;
        @(posedge sys_clk); #1 enable = 1'b1;
        @(posedge sys_clk); #1 enable = 1'b0;
        set_v = -16'sd32768;
        det_v = 16'sd32767;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge sys_clk); #1;
            if (done && lat < 0) lat = k;
            if (lat >= 0) break;
        end
    endtask

    task automatic clear_int();
        @(posedge sys_clk); #1 clear = 1'b1;
        @(posedge sys_clk); #1 clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; set_v = '0; det_v = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (q_out !== 16'sd0) begin failures++; $display("FAIL reset_out: got %0d expected 0", q_out); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run_op(16'sd1000, 16'sd0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++; if (q_out !== 16'sd1250) begin failures++; $display("FAIL basic_out1: got %0d expected 1250", q_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
        @(posedge sys_clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width: got %b expected 0", done); end
        checks++; if (q_out !== 16'sd1250) begin failures++; $display("FAIL basic_hold: got %0d expected 1250", q_out); end
        run_op(16'sd1000, 16'sd0, lat);
        checks++; if (q_out !== 16'sd1500) begin failures++; $display("FAIL basic_out2: got %0d expected 1500", q_out); end
    endtask

    task automatic test_saturation();
        int lat;
        clear_int();
        run_op(16'sd30000, -16'sd30000, lat);
        checks++; if (q_out !== 16'sd8000) begin failures++; $display("FAIL sat_pos_out: got %0d expected 8000", q_out); end
        run_op(-16'sd8000, 16'sd0, lat);
        checks++; if (q_out !== -16'sd2000) begin failures++; $display("FAIL sat_pos_acc_clamp: got %0d expected -2000", q_out); end
        run_op(-16'sd30000, 16'sd30000, lat);
        checks++; if (q_out !== -16'sd8000) begin failures++; $display("FAIL sat_neg_out: got %0d expected -8000", q_out); end
        run_op(16'sd8000, 16'sd0, lat);
        checks++; if (q_out !== 16'sd2000) begin failures++; $display("FAIL sat_neg_acc_clamp: got %0d expected 2000", q_out); end
    endtask

    task automatic test_floor();
        int lat;
        clear_int();
        run_op(16'sd0, 16'sd1, lat);
        checks++; if (q_out !== -16'sd2) begin failures++; $display("FAIL floor_neg: got %0d expected -2", q_out); end
    endtask

    task automatic test_back_to_back();
        int dones;
        int second_k;
        clear_int();
        set_v = 16'sd1000; det_v = 16'sd0;
        @(posedge sys_clk); #1 enable = 1'b1;
        @(posedge sys_clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_start: got %b expected 1", busy); end
        dones = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge sys_clk); #1;
            if (done) dones++;
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_n3: got %b expected 1", busy); end
        enable = 1'b0;
        @(posedge sys_clk); #1;
        if (done) dones++;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done_n4: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_n4: got %b expected 0", busy); end
        checks++; if (q_out !== 16'sd1250) begin failures++; $display("FAIL b2b_out1: got %0d expected 1250", q_out); end
        enable = 1'b1;
        @(posedge sys_clk); #1 enable = 1'b0;
        second_k = -1;
        for (int k = 6; k <= 9; k++) begin
            @(posedge sys_clk); #1;
            if (done && k < 9) dones++;
            if (done && second_k < 0) second_k = k;
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL b2b_single_done: got %0d expected 1", dones); end
        checks++; if (second_k !== 9) begin failures++; $display("FAIL b2b_retrigger_edge: got %0d expected 9", second_k); end
        checks++; if (q_out !== 16'sd1500) begin failures++; $display("FAIL b2b_out2: got %0d expected 1500", q_out); end
    endtask

    task automatic test_clear();
        int lat;
        clear_int();
        run_op(16'sd1000, 16'sd0, lat);
        run_op(16'sd1000, 16'sd0, lat);
        checks++; if (q_out !== 16'sd1500) begin failures++; $display("FAIL clear_pre: got %0d expected 1500", q_out); end
        clear_int();
        run_op(16'sd1000, 16'sd0, lat);
        checks++; if (q_out !== 16'sd1250) begin failures++; $display("FAIL clear_idle: got %0d expected 1250", q_out); end
        set_v = 16'sd1000; det_v = 16'sd0;
        @(posedge sys_clk); #1 enable = 1'b1;
        @(posedge sys_clk); #1 enable = 1'b0;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1 clear = 1'b1;
        @(posedge sys_clk); #1 clear = 1'b0;
        @(posedge sys_clk); #1;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL clear_acc_done: got %b expected 1", done); end
        checks++; if (q_out !== 16'sd1000) begin failures++; $display("FAIL clear_acc_edge: got %0d expected 1000", q_out); end
        run_op(16'sd1000, 16'sd0, lat);
        checks++; if (q_out !== 16'sd1250) begin failures++; $display("FAIL clear_after_acc: got %0d expected 1250", q_out); end
        set_v = 16'sd1000; det_v = 16'sd0;
        @(posedge sys_clk); #1 enable = 1'b1; clear = 1'b1;
        @(posedge sys_clk); #1 enable = 1'b0; clear = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge sys_clk); #1;
            if (done && lat < 0) lat = k;
            if (lat >= 0) break;
        end
        checks++; if (lat !== 4) begin failures++; $display("FAIL clear_with_enable_lat: got %0d expected 4", lat); end
        checks++; if (q_out !== 16'sd1250) begin failures++; $display("FAIL clear_with_enable_out: got %0d expected 1250", q_out); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int dones;
        set_v = 16'sd1000; det_v = 16'sd0;
        @(posedge sys_clk); #1 enable = 1'b1;
        @(posedge sys_clk); #1 enable = 1'b0;
        @(posedge sys_clk); #1;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (q_out !== 16'sd0) begin failures++; $display("FAIL rst_mid_out: got %0d expected 0", q_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        @(posedge sys_clk);
        @(posedge sys_clk); #1 reset_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge sys_clk); #1;
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d expected 0", dones); end
        run_op(16'sd1000, 16'sd0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL rst_mid_next_lat: got %0d expected 4", lat); end
        checks++; if (q_out !== 16'sd1250) begin failures++; $display("FAIL rst_mid_next_out: got %0d expected 1250", q_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_floor();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/speed_loop_control.md
Name: speed_loop_control

Overview:
- Speed-loop PI controller directly downstream of the position-loop stage.
- Consumes the position-mode speed set value (16-bit signed) and its 1-cycle completion flag as a start strobe.
- Computes a PI correction from the detected rotor speed and outputs the q-axis current set value for the current loop.
- Multi-cycle sequenced datapath with integrator anti-windup, output saturation, and a done pulse.

Parameters:
- DATA_WIDTH, 16, width of speed set/detect values and current set output
- KP, 16'd1024, proportional gain, unsigned, fixed point with FRAC fractional bits
- KI, 16'd256, integral gain per update, unsigned, fixed point with FRAC fractional bits
- FRAC, 10, fractional bits of KP/KI; right shift applied to the PI sum
- OUT_MAX, 16'sd8000, symmetric output limit (+/-OUT_MAX), positive

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- speed_loop_control_enable_in  input  1  start strobe (the position-loop done flag); sampled only in IDLE
- integral_clear_in  input  1  synchronous clear of the integrator (mode change / fault)
- pmsm_speed_set_value_in  input  DATA_WIDTH  signed speed set value
- pmsm_detect_speed_value_in  input  DATA_WIDTH  signed measured speed
- pmsm_current_q_set_value_out  output  DATA_WIDTH  signed q-axis current set value, registered
- speed_loop_control_done_out  output  1  one-cycle pulse when a new output is valid
- speed_loop_busy_out  output  1  high while a computation is in flight (ERR..OUT)

Behaviour:
- Reset: all outputs 0, integrator accumulator 0, FSM in IDLE; reset may assert in any state and aborts the computation with no done pulse.
- States are IDLE, ERR, MUL, ACC, OUT.
- IDLE -> ERR on the edge that samples enable=1:
  - e = set - detect, sign-extended to DATA_WIDTH+1 bits (17).
  - set and detect are captured at that edge only; later input changes are ignored.
- ERR -> MUL: p = KP*e and i = KI*e, both signed with KP/KI zero-extended; 34-bit signed products.
- MUL -> ACC:
  - acc_n = acc + i, 35-bit intermediate.
  - Clamp acc_n to [-(OUT_MAX<<FRAC), +(OUT_MAX<<FRAC)].
  - Store into the 34-bit acc (anti-windup).
- ACC -> OUT:
  - s = (p + acc) >>> FRAC, arithmetic shift, i.e. floor toward -inf.
  - Saturate s to [-OUT_MAX, +OUT_MAX].
  - Register s to pmsm_current_q_set_value_out.
  - Assert done_out for exactly one cycle.
- OUT -> IDLE unconditionally.
- Latency: with enable sampled at edge N, output and done update at edge N+4. Minimum re-trigger period is 5 cycles; enable in IDLE at N+5 is accepted.
- Busy is high from edge N+1 through edge N+4, i.e. states ERR, MUL, ACC, OUT.
- Enable while busy is ignored and dropped, not queued.
- integral_clear_in=1:
  - acc <= 0 at that edge, in any state.
  - If it coincides with the ACC-state update, clear wins: acc=0 and s uses acc=0.
  - Enable sampled in the same cycle is still accepted.
- Output holds its last value between updates. Done is low except on the OUT edge.

Test Plan:
- Reset, then KP=1024, KI=256, FRAC=10, set=1000, detect=0, pulse enable -> done exactly 4 cycles later, out=1250 (p=1024000, acc=256000); repeat -> out=1500, acc=512000.
- set=30000, detect=-30000 (e=60000) -> acc clamps to 8192000, out=+8000; reverse signs -> acc reaches -8192000 after enough updates, out=-8000.
- From a cleared integrator, set=0, detect=1 (e=-1) -> acc=-256, out=floor(-1280/1024)=-2.
- Enable re-pulsed at edges N+1..N+3 -> exactly one done and busy low only after N+4; re-pulse at N+5 -> second done at N+9.
- integral_clear_in asserted with acc=512000, then set=1000, detect=0 -> out=1250; clear held during the ACC edge -> out=1000.
- reset_n dropped while in MUL -> out=0, done never asserted, acc=0, next enable behaves as from power-up.
